uart_tx_serializer: RTL and testbench

Transmit-side serializer for the APB UART. It captures one `DATA_WIDTH` word and shifts it onto the `TX` line LSB-first as a back-to-back sequence of UART frames. Each frame is start bit, `frame_length` data bits, optional parity and one or two stop bits, with each bit lasting 16 ticks. It is the line-level counterpart of the receive deserializer and uses the same frame, parity and stop-bit configuration encoding, so the two blocks interoperate in loopback.

---
 rtl/uart_tx_serializer.sv | 187 ++++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
//
// Transmit-side serializer for the APB UART. One DATA_WIDTH word is captured
// on request and shifted out LSB-first as back-to-back UART frames:
// start bit, N data bits (N = 5..8, anything else means 8), optional parity,
// then one or two stop bits. Every line bit lasts 16 ticks of tx_tick.
// The last frame of a word is padded with zeros past DATA_WIDTH.
//
// Ports
//   tx_tick      in   16x oversampled bit clock (the only clock, rising edge)
//   PRESETn      in   asynchronous active-low reset
//   tx_start     in   transmit request, only looked at while idle
//   tx_data_in   in   word to send, captured together with tx_start
//   frame_length in   data bits per frame (5..8 legal, others act as 8)
//   stop_bit     in   0 = one stop bit, 1 = two stop bits
//   parity       in   [1] enables parity; 10 = odd (~^bits), 11 = even (^bits)
//   TX           out  registered serial line, idles high
//   tx_busy      out  high from acceptance until the tick after tx_done
//   tx_done      out  one-tick pulse when the last stop bit of the word ends
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  tx_tick,
  input  logic                  PRESETn,
  input  logic                  tx_start,
  input  logic [DATA_WIDTH-1:0] tx_data_in,
  input  logic [3:0]            frame_length,
  input  logic                  stop_bit,
  input  logic [1:0]            parity,
  output logic                  TX,
  output logic                  tx_busy,
  output logic                  tx_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2,
    S_DONE
  } state_t;

  localparam logic [6:0] LP_WIDTH = 7'(DATA_WIDTH);

  state_t                r_state;
  state_t                w_state_nxt;

  // control (reset)
  logic [3:0]            r_tick;
  logic [5:0]            r_index;
  logic [3:0]            r_bit;
  logic                  r_tx;
  logic                  r_busy;
  logic                  r_done;

  // captured word, configuration and running frame parity (not reset)
  logic [DATA_WIDTH-1:0] r_shift;
  logic [3:0]            r_len;
  logic                  r_stop2;
  logic                  r_par_en;
  logic                  r_par_even;
  logic                  r_par;

  logic                  w_accept;
  logic                  w_bit_end;
  logic                  w_last_data;
  logic                  w_word_left;
  logic                  w_xor;
  logic                  w_par_bit;
  logic                  w_tx_nxt;

  function automatic logic [3:0] eff_len(input logic [3:0] fl);
    if (fl >= 4'd5 && fl <= 4'd8) begin
      return fl;
    end
    return 4'd8;
  endfunction

  assign w_accept    = (r_state == S_IDLE) && tx_start;
  assign w_bit_end   = (r_tick == 4'd15);
  assign w_last_data = (r_bit == (r_len - 4'd1));
  // Index saturates at DATA_WIDTH, so pad bits never count as word bits.
  assign w_word_left = ({1'b0, r_index} < LP_WIDTH);
  // Parity covers the data bit finishing on this edge as well.
  assign w_xor       = r_par ^ r_shift[0];
  assign w_par_bit   = r_par_even ? w_xor : ~w_xor;

  always_ff @(posedge tx_tick or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus the next line level. TX is registered from the level the
  // line must carry in the state being entered, so bit edges are glitch free.
  always_comb begin
    w_state_nxt = r_state;
    w_tx_nxt    = 1'b1;
    case (r_state)
      S_IDLE:   if (tx_start)  w_state_nxt = S_START;
      S_START:  if (w_bit_end) w_state_nxt = S_DATA;
      S_DATA: begin
        if (w_bit_end && w_last_data) begin
          w_state_nxt = r_par_en ? S_PARITY : S_STOP1;
        end
      end
      S_PARITY: if (w_bit_end) w_state_nxt = S_STOP1;
      S_STOP1: begin
        if (w_bit_end) begin
          if (r_stop2)          w_state_nxt = S_STOP2;
          else if (w_word_left) w_state_nxt = S_START;
          else                  w_state_nxt = S_DONE;
        end
      end
      S_STOP2: begin
        if (w_bit_end) begin
          w_state_nxt = w_word_left ? S_START : S_DONE;
        end
      end
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase

    case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      // Shift happens at the end of each data bit; the following bit is
      // already visible at r_shift[1] on that edge. Exhausted bits read 0.
      S_DATA:   w_tx_nxt = (r_state == S_DATA && w_bit_end) ? r_shift[1] : r_shift[0];
      S_PARITY: w_tx_nxt = (r_state == S_DATA) ? w_par_bit : r_tx;
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge tx_tick or negedge PRESETn) begin
    if (!PRESETn) begin
      r_tick  <= 4'd0;
      r_index <= 6'd0;
      r_bit   <= 4'd0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_tick  <= 4'd0;
        r_index <= 6'd0;
        r_bit   <= 4'd0;
      end else if (r_state != S_IDLE && r_state != S_DONE) begin
        // Wraps 15 -> 0 exactly when the state advances.
        r_tick <= r_tick + 4'd1;
      end
      if (r_state == S_DATA && w_bit_end) begin
        if (w_word_left) begin
          r_index <= r_index + 6'd1;
        end
        r_bit <= w_last_data ? 4'd0 : (r_bit + 4'd1);
      end
      r_tx   <= w_tx_nxt;
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= (w_state_nxt == S_DONE);
    end
  end

  always_ff @(posedge tx_tick) begin
    if (w_accept) begin
      r_shift    <= tx_data_in;
      r_len      <= eff_len(frame_length);
      r_stop2    <= stop_bit;
      r_par_en   <= parity[1];
      r_par_even <= parity[0];
      r_par      <= 1'b0;
    end else if (r_state == S_DATA && w_bit_end) begin
      r_shift <= r_shift >> 1;
      r_par   <= w_last_data ? 1'b0 : w_xor;
    end
  end

  assign TX      = r_tx;
  assign tx_busy = r_busy;
  assign tx_done = r_done;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_serializer
//
// Directed bench for uart_tx_serializer (DATA_WIDTH = 32). Each transaction
// records the TX level on every tick after the request edge and compares it
// with a frame-by-frame reference line, alongside hand-computed bit values,
// tx_done timing and tx_busy behaviour.
// -----------------------------------------------------------------------------
module tb_uart_tx_serializer;

  logic        tx_tick = 1'b0;
  logic        PRESETn;
  logic        tx_start;
  logic [31:0] tx_data_in;
  logic [3:0]  frame_length;
  logic        stop_bit;
  logic [1:0]  parity;
  logic        TX;
  logic        tx_busy;
  logic        tx_done;

  int checks = 0;
  int errors = 0;

  logic line_q [0:2047];
  logic exp_q  [0:2047];
  int   done_k;
  int   done_pulses;
  int   busy_low;
  int   total;

  uart_tx_serializer #(.DATA_WIDTH(32)) dut (
    .tx_tick      (tx_tick),
    .PRESETn      (PRESETn),
    .tx_start     (tx_start),
    .tx_data_in   (tx_data_in),
    .frame_length (frame_length),
    .stop_bit     (stop_bit),
    .parity       (parity),
    .TX           (TX),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done)
  );

  always #5 tx_tick = ~tx_tick;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic ln(input int k);
    return line_q[k[10:0]];
  endfunction

  task automatic put_bit(inout int k, input logic v);
    for (int t = 0; t < 16; t++) begin
      exp_q[k[10:0]] = v;
      k++;
    end
  endtask

  // Reference line: frames of start, N data (zero past bit 31), parity, stops.
  task automatic build_exp(input logic [31:0] d, input int n, input bit pen,
                           input bit peven, input int ns, output int tot);
    int   k;
    int   frames;
    int   idx;
    logic b;
    logic x;
    k = 0;
    frames = (32 + n - 1) / n;
    for (int f = 0; f < frames; f++) begin
      put_bit(k, 1'b0);
      x = 1'b0;
      for (int j = 0; j < n; j++) begin
        idx = f * n + j;
        b = (idx < 32) ? d[idx[4:0]] : 1'b0;
        x = x ^ b;
        put_bit(k, b);
      end
      if (pen) put_bit(k, peven ? x : ~x);
      for (int s = 0; s < ns; s++) put_bit(k, 1'b1);
    end
    tot = k;
  endtask

  // Issues a request and records TX until tx_done (bounded). Optionally pokes
  // a second request with different inputs at tick poke_k while busy.
  task automatic send(input logic [31:0] d, input logic [3:0] fl,
                      input logic sb, input logic [1:0] par, input int poke_k);
    tx_data_in   = d;
    frame_length = fl;
    stop_bit     = sb;
    parity       = par;
    tx_start     = 1'b1;
    @(posedge tx_tick); #1;
    tx_start    = 1'b0;
    line_q[0]   = TX;
    done_k      = -1;
    done_pulses = 0;
    busy_low    = 0;
    chk1("start_tx_low", TX, 1'b0);
    chk1("start_busy_high", tx_busy, 1'b1);
    for (int k = 1; k < 2048 && done_k < 0; k++) begin
      if (k == poke_k) begin
        tx_start     = 1'b1;
        tx_data_in   = 32'h0F0F_0F0F;
        frame_length = 4'd5;
        parity       = 2'b11;
        stop_bit     = 1'b1;
      end else if (k == poke_k + 1) begin
        tx_start = 1'b0;
      end
      @(posedge tx_tick); #1;
      line_q[k[10:0]] = TX;
      if (!tx_busy) busy_low++;
      if (tx_done) begin
        done_k = k;
        done_pulses++;
      end
    end
    tx_start = 1'b0;
    @(posedge tx_tick); #1;
    chk1("done_one_tick", tx_done, 1'b0);
    chk1("busy_released", tx_busy, 1'b0);
    chk1("idle_tx_high", TX, 1'b1);
    chkv("busy_held_during_word", busy_low, 0);
  endtask

  task automatic cmp_line(input string tag, input int tot);
    int bad;
    bad = 0;
    for (int k = 0; k < tot; k++) begin
      if (line_q[k[10:0]] !== exp_q[k[10:0]]) bad++;
    end
    chkv(tag, bad, 0);
  endtask

  function automatic logic [7:0] frame_byte(input int base);
    logic [7:0] r;
    r = 8'h00;
    for (int j = 0; j < 8; j++) r[j[2:0]] = ln(base + 16 * (1 + j) + 8);
    return r;
  endfunction

  initial begin
    logic [9:0] f0;
    logic [4:0] last5;

    PRESETn      = 1'b0;
    tx_start     = 1'b0;
    tx_data_in   = 32'h0;
    frame_length = 4'd8;
    stop_bit     = 1'b0;
    parity       = 2'b00;
    #12;
    chk1("reset_tx", TX, 1'b1);
    chk1("reset_busy", tx_busy, 1'b0);
    chk1("reset_done", tx_done, 1'b0);
    @(posedge tx_tick); #3;
    PRESETn = 1'b1;
    @(posedge tx_tick); #1;

    // Reset in the middle of a frame: tick 40 is data bit 1 of 0x34 (a 0).
    tx_data_in = 32'hA5C3_1234;
    tx_start   = 1'b1;
    @(posedge tx_tick); #1;
    tx_start = 1'b0;
    repeat (40) @(posedge tx_tick);
    #3;
    chk1("prereset_tx_low", TX, 1'b0);
    chk1("prereset_busy", tx_busy, 1'b1);
    PRESETn = 1'b0;
    #1;
    chk1("midreset_tx", TX, 1'b1);
    chk1("midreset_busy", tx_busy, 1'b0);
    chk1("midreset_done", tx_done, 1'b0);
    repeat (2) @(posedge tx_tick);
    #3;
    PRESETn = 1'b1;
    repeat (20) @(posedge tx_tick);
    #1;
    chk1("no_resume_tx", TX, 1'b1);
    chk1("no_resume_busy", tx_busy, 1'b0);

    // 8N1 after the reset, also the basic 8N1 word.
    send(32'hA5C3_1234, 4'd8, 1'b0, 2'b00, -1);
    build_exp(32'hA5C3_1234, 8, 1'b0, 1'b0, 1, total);
    chkv("8n1_done_tick", done_k, 640);
    cmp_line("8n1_line", total);
    for (int i = 0; i < 10; i++) f0[9 - i] = ln(16 * i + 8);
    chkv("8n1_frame0_bits", {22'h0, f0}, 32'h0000_0059);
    chkv("8n1_byte0", {24'h0, frame_byte(0)},   32'h34);
    chkv("8n1_byte1", {24'h0, frame_byte(160)}, 32'h12);
    chkv("8n1_byte2", {24'h0, frame_byte(320)}, 32'hC3);
    chkv("8n1_byte3", {24'h0, frame_byte(480)}, 32'hA5);

    // Even parity, low byte 0x07: three ones -> parity bit 1.
    send(32'h0000_0007, 4'd8, 1'b0, 2'b11, -1);
    build_exp(32'h0000_0007, 8, 1'b1, 1'b1, 1, total);
    chkv("even_done_tick", done_k, 704);
    chk1("even_parity_bit", ln(16 * 9 + 8), 1'b1);
    cmp_line("even_line", total);

    // Odd parity, same data -> parity bit 0.
    send(32'h0000_0007, 4'd8, 1'b0, 2'b10, -1);
    build_exp(32'h0000_0007, 8, 1'b1, 1'b0, 1, total);
    chkv("odd_done_tick", done_k, 704);
    chk1("odd_parity_bit", ln(16 * 9 + 8), 1'b0);
    chk1("odd_parity_zero_frame", ln(176 + 16 * 9 + 8), 1'b1);
    cmp_line("odd_line", total);

    // 5-bit frames, two stops, all ones: 7 frames, last frame padded.
    send(32'hFFFF_FFFF, 4'd5, 1'b1, 2'b00, -1);
    build_exp(32'hFFFF_FFFF, 5, 1'b0, 1'b0, 2, total);
    chkv("5n2_done_tick", done_k, 896);
    for (int j = 0; j < 5; j++) last5[j[2:0]] = ln(768 + 16 * (1 + j) + 8);
    chkv("5n2_last_frame_data", {27'h0, last5}, 32'h03);
    chk1("5n2_stop2_high", ln(768 + 16 * 7 + 8), 1'b1);
    cmp_line("5n2_line", total);

    // Request with new data and config while busy must be ignored.
    send(32'h1234_5678, 4'd8, 1'b0, 2'b00, 100);
    build_exp(32'h1234_5678, 8, 1'b0, 1'b0, 1, total);
    chkv("busy_poke_done_tick", done_k, 640);
    chkv("busy_poke_done_count", done_pulses, 1);
    cmp_line("busy_poke_line", total);
    begin
      int extra_done;
      int tx_low;
      extra_done = 0;
      tx_low     = 0;
      for (int k = 0; k < 40; k++) begin
        @(posedge tx_tick); #1;
        if (tx_done) extra_done++;
        if (!TX) tx_low++;
      end
      chkv("busy_poke_no_extra_done", extra_done, 0);
      chkv("busy_poke_line_idle", tx_low, 0);
    end

    // Illegal frame length behaves as 8.
    send(32'hA5C3_1234, 4'd3, 1'b0, 2'b00, -1);
    build_exp(32'hA5C3_1234, 8, 1'b0, 1'b0, 1, total);
    chkv("len3_done_tick", done_k, 640);
    cmp_line("len3_line", total);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
